// File: rtl/tcam_search_ctrl.sv
// Command front-end for the 64x28 TCAM wrapper: arbitrates rule writes and
// key searches onto the single memory port, tracks searches through the
// fixed read latency and buffers tagged results in an in-order FIFO.
module tcam_search_ctrl #(
  parameter int KEY_W     = 28,
  parameter int WADDR_W   = 10,
  parameter int DATA_W    = 32,
  parameter int MASK_W    = 4,
  parameter int PMA_W     = 6,
  parameter int TAG_W     = 4,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 4,
  parameter int WR_BURST  = 4
) (
  input  logic               in_clk,
  input  logic               in_rstn,
  input  logic               in_srch_valid,
  output logic               out_srch_ready,
  input  logic [KEY_W-1:0]   in_srch_key,
  input  logic [TAG_W-1:0]   in_srch_tag,
  input  logic               in_wr_valid,
  output logic               out_wr_ready,
  input  logic [WADDR_W-1:0] in_wr_addr,
  input  logic [DATA_W-1:0]  in_wr_data,
  input  logic [MASK_W-1:0]  in_wr_mask,
  output logic               out_rsp_valid,
  input  logic               in_rsp_ready,
  output logic [PMA_W-1:0]   out_rsp_pma,
  output logic [TAG_W-1:0]   out_rsp_tag,
  output logic               out_mem_csb,
  output logic               out_mem_web,
  output logic [MASK_W-1:0]  out_mem_wmask,
  output logic [KEY_W-1:0]   out_mem_addr,
  output logic [DATA_W-1:0]  out_mem_wdata,
  input  logic [PMA_W-1:0]   in_mem_pma,
  output logic               out_idle
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RSP_DEPTH + RD_LAT + 2);
  localparam int BST_W = $clog2(WR_BURST + 1);

  logic             wr_grant;
  logic             srch_grant;
  logic             credit_ok;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] occupancy;
  logic [BST_W-1:0] burst_cnt;

  logic [RD_LAT:0]  pipe_vld;
  logic [TAG_W-1:0] pipe_tag [RD_LAT+1];

  logic [PMA_W-1:0] fifo_pma [RSP_DEPTH];
  logic [TAG_W-1:0] fifo_tag [RSP_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic             push;
  logic             pop;

  // Count searches still travelling through the latency pipe; a result only
  // leaves the pipe by entering the FIFO, so pipe + FIFO bounds outstanding work.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_vld[i]);
    end
  end

  assign occupancy = inflight + fifo_count;
  assign credit_ok = occupancy < CNT_W'(RSP_DEPTH);

  // Pick at most one operation per cycle: writes first, searches when no write
  // is pending or when a waiting search has seen a full write burst.
  always_comb begin
    wr_grant   = 1'b0;
    srch_grant = 1'b0;
    if (in_rstn) begin
      if (in_srch_valid && credit_ok &&
          (!in_wr_valid || burst_cnt == BST_W'(WR_BURST))) begin
        srch_grant = 1'b1;
      end else if (in_wr_valid) begin
        wr_grant = 1'b1;
      end
    end
  end

  assign out_wr_ready   = wr_grant;
  assign out_srch_ready = srch_grant;

  // Count writes that overtake a waiting search so it cannot starve.
  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      burst_cnt <= '0;
    end else if (srch_grant || !in_srch_valid) begin
      burst_cnt <= '0;
    end else if (wr_grant && burst_cnt != BST_W'(WR_BURST)) begin
      burst_cnt <= burst_cnt + BST_W'(1);
    end
  end

  // Register the granted operation onto the memory port one cycle later.
  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      out_mem_csb   <= 1'b1;
      out_mem_web   <= 1'b1;
      out_mem_wmask <= '0;
      out_mem_addr  <= '0;
      out_mem_wdata <= '0;
    end else if (wr_grant) begin
      out_mem_csb   <= 1'b0;
      out_mem_web   <= 1'b0;
      out_mem_wmask <= in_wr_mask;
      out_mem_addr  <= {{(KEY_W-WADDR_W){1'b0}}, in_wr_addr};
      out_mem_wdata <= in_wr_data;
    end else if (srch_grant) begin
      out_mem_csb   <= 1'b0;
      out_mem_web   <= 1'b1;
      out_mem_wmask <= '0;
      out_mem_addr  <= in_srch_key;
      out_mem_wdata <= '0;
    end else begin
      out_mem_csb   <= 1'b1;
      out_mem_web   <= 1'b1;
      out_mem_wmask <= '0;
      out_mem_addr  <= '0;
      out_mem_wdata <= '0;
    end
  end

  // Shift each granted search's tag along so it lines up with its match address.
  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      pipe_vld <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= srch_grant;
      pipe_tag[0] <= in_srch_tag;
      for (int i = 1; i <= RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  assign push = pipe_vld[RD_LAT];
  assign pop  = out_rsp_valid && in_rsp_ready;

  // Capture the match address and tag into the in-order response buffer.
  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      wr_ptr <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_pma[i] <= '0;
        fifo_tag[i] <= '0;
      end
    end else if (push) begin
      fifo_pma[wr_ptr] <= in_mem_pma;
      fifo_tag[wr_ptr] <= pipe_tag[RD_LAT];
      wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);
    end
  end

  // Advance the read side and keep occupancy; push with pop leaves it unchanged.
  always_ff @(posedge in_clk or negedge in_rstn) begin
    if (!in_rstn) begin
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH-1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign out_rsp_valid = (fifo_count != '0);
  assign out_rsp_pma   = fifo_pma[rd_ptr];
  assign out_rsp_tag   = fifo_tag[rd_ptr];

  assign out_idle = !in_srch_valid && !in_wr_valid && (pipe_vld == '0) &&
                    (fifo_count == '0) && out_mem_csb;

  // The credit check must make a push into a full buffer unreachable.
  a_no_overflow : assert property (@(posedge in_clk) disable iff (!in_rstn)
    !(push && fifo_count == CNT_W'(RSP_DEPTH)));

endmodule

// File: tb/tb_tcam_search_ctrl.sv
// Directed and randomised checks of tcam_search_ctrl with a TCAM memory model
// and an in-order scoreboard of expected {pma, tag} results.
module tb_tcam_search_ctrl;

  localparam int RD_LAT = 2;

  typedef struct packed {
    logic [5:0] pma;
    logic [3:0] tag;
  } exp_t;

  logic        in_clk = 1'b0;
  logic        in_rstn = 1'b1;
  logic        in_srch_valid = 1'b0;
  logic        out_srch_ready;
  logic [27:0] in_srch_key = '0;
  logic [3:0]  in_srch_tag = '0;
  logic        in_wr_valid = 1'b0;
  logic        out_wr_ready;
  logic [9:0]  in_wr_addr = '0;
  logic [31:0] in_wr_data = '0;
  logic [3:0]  in_wr_mask = '0;
  logic        out_rsp_valid;
  logic        in_rsp_ready = 1'b0;
  logic [5:0]  out_rsp_pma;
  logic [3:0]  out_rsp_tag;
  logic        out_mem_csb;
  logic        out_mem_web;
  logic [3:0]  out_mem_wmask;
  logic [27:0] out_mem_addr;
  logic [31:0] out_mem_wdata;
  logic [5:0]  in_mem_pma;
  logic        out_idle;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic       mv [RD_LAT+1];
  logic [5:0] mp [RD_LAT+1];
  logic [5:0] junk = '0;

  tcam_search_ctrl dut (
    .in_clk(in_clk), .in_rstn(in_rstn),
    .in_srch_valid(in_srch_valid), .out_srch_ready(out_srch_ready),
    .in_srch_key(in_srch_key), .in_srch_tag(in_srch_tag),
    .in_wr_valid(in_wr_valid), .out_wr_ready(out_wr_ready),
    .in_wr_addr(in_wr_addr), .in_wr_data(in_wr_data), .in_wr_mask(in_wr_mask),
    .out_rsp_valid(out_rsp_valid), .in_rsp_ready(in_rsp_ready),
    .out_rsp_pma(out_rsp_pma), .out_rsp_tag(out_rsp_tag),
    .out_mem_csb(out_mem_csb), .out_mem_web(out_mem_web),
    .out_mem_wmask(out_mem_wmask), .out_mem_addr(out_mem_addr),
    .out_mem_wdata(out_mem_wdata), .in_mem_pma(in_mem_pma),
    .out_idle(out_idle)
  );

  always #5 in_clk = ~in_clk;

  // Match address the modelled TCAM returns for a key.
  function automatic logic [5:0] pma_of(input logic [27:0] k);
    if (k == 28'h0ABCDEF) return 6'd17;
    return k[5:0] ^ k[13:8];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i <= RD_LAT; i++) begin
      mv[i] = 1'b0;
      mp[i] = '0;
    end
  end

  // Memory model: a search seen on the port in cycle P drives its pma during
  // the clock edge that ends cycle P+RD_LAT; other cycles carry random junk.
  always @(negedge in_clk) begin
    mv[0] <= (out_mem_csb === 1'b0) && (out_mem_web === 1'b1);
    mp[0] <= pma_of(out_mem_addr);
    for (int i = 1; i <= RD_LAT; i++) begin
      mv[i] <= mv[i-1];
      mp[i] <= mp[i-1];
    end
    junk <= 6'($urandom);
  end

  assign in_mem_pma = mv[RD_LAT] ? mp[RD_LAT] : junk;

  // Scoreboard push on every accepted search.
  always @(negedge in_clk) begin
    if (in_rstn && in_srch_valid && out_srch_ready) begin
      exp_t e;
      e.pma = pma_of(in_srch_key);
      e.tag = in_srch_tag;
      sb.push_back(e);
    end
  end

  // Scoreboard pop and compare on every consumed response.
  always @(negedge in_clk) begin
    if (in_rstn && out_rsp_valid && in_rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 64'(out_rsp_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rsp_pma", 64'(out_rsp_pma), 64'(e.pma));
        check("rsp_tag", 64'(out_rsp_tag), 64'(e.tag));
      end
    end
  end

  task automatic applyStimulus(input logic sv, input logic [27:0] key, input logic [3:0] tag,
                               input logic wv, input logic [9:0] wa, input logic [31:0] wd,
                               input logic [3:0] wm, input logic rr);
    in_srch_valid = sv;
    in_srch_key   = key;
    in_srch_tag   = tag;
    in_wr_valid   = wv;
    in_wr_addr    = wa;
    in_wr_data    = wd;
    in_wr_mask    = wm;
    in_rsp_ready  = rr;
  endtask

  task automatic checkOutput(input string tag);
    int cyc;
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    cyc = 0;
    while (!(out_idle === 1'b1) && cyc < 60) begin
      @(posedge in_clk);
      #1;
      cyc++;
    end
    check({tag, "_idle"}, 64'(out_idle), 64'd1);
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int accepted;
    int wr_sent;
    logic srch_done;

    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int accepted;
    int wr_sent;
    logic srch_done;

    // Reset state, with both requests valid so ready gating is visible.
    #1 in_rstn = 1'b0;
    applyStimulus(1'b1, 28'h1, 4'h1, 1'b1, 10'h1, 32'h1, 4'h1, 1'b0);
    #7;
    check("rst_csb", 64'(out_mem_csb), 64'd1);
    check("rst_web", 64'(out_mem_web), 64'd1);
    check("rst_wmask", 64'(out_mem_wmask), 64'd0);
    check("rst_addr", 64'(out_mem_addr), 64'd0);
    check("rst_wdata", 64'(out_mem_wdata), 64'd0);
    check("rst_rsp_valid", 64'(out_rsp_valid), 64'd0);
    check("rst_rsp_pma", 64'(out_rsp_pma), 64'd0);
    check("rst_rsp_tag", 64'(out_rsp_tag), 64'd0);
    check("rst_wr_ready", 64'(out_wr_ready), 64'd0);
    check("rst_srch_ready", 64'(out_srch_ready), 64'd0);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, '0, 1'b1);
    #1;
    check("rst_idle", 64'(out_idle), 64'd1);
    @(posedge in_clk);
    #1 in_rstn = 1'b1;

    // Single search with known latency.
    @(posedge in_clk); #1;
    applyStimulus(1'b1, 28'h0ABCDEF, 4'd3, 1'b0, '0, '0, '0, 1'b1);
    @(negedge in_clk);
    check("s1_ready_T", 64'(out_srch_ready), 64'd1);
    @(posedge in_clk); #1;
    in_srch_valid = 1'b0;
    @(negedge in_clk);
    check("s1_port_csb", 64'(out_mem_csb), 64'd0);
    check("s1_port_web", 64'(out_mem_web), 64'd1);
    check("s1_port_addr", 64'(out_mem_addr), 64'h0ABCDEF);
    @(posedge in_clk); #1;
    @(posedge in_clk); #1;
    check("s1_valid_T3", 64'(out_rsp_valid), 64'd0);
    @(posedge in_clk); #1;
    check("s1_valid_T4", 64'(out_rsp_valid), 64'd1);
    check("s1_pma_T4", 64'(out_rsp_pma), 64'd17);
    check("s1_tag_T4", 64'(out_rsp_tag), 64'd3);
    checkOutput("s1");

    // Single write: port contents and no response.
    @(posedge in_clk); #1;
    applyStimulus(1'b0, '0, '0, 1'b1, 10'h2A5, 32'hDEADBEEF, 4'b0101, 1'b1);
    @(negedge in_clk);
    check("w1_ready", 64'(out_wr_ready), 64'd1);
    @(posedge in_clk); #1;
    in_wr_valid = 1'b0;
    @(negedge in_clk);
    check("w1_csb", 64'(out_mem_csb), 64'd0);
    check("w1_web", 64'(out_mem_web), 64'd0);
    check("w1_addr", 64'(out_mem_addr), 64'h00002A5);
    check("w1_wmask", 64'(out_mem_wmask), 64'b0101);
    check("w1_wdata", 64'(out_mem_wdata), 64'hDEADBEEF);
    @(posedge in_clk); #1;
    check("w1_port_idle", 64'(out_mem_csb), 64'd1);
    repeat (3) @(posedge in_clk);
    #1;
    check("w1_no_rsp", 64'(out_rsp_valid), 64'd0);
    checkOutput("w1");

    // Eight writes against one waiting search: search lands in cycle 4.
    wr_sent = 0;
    srch_done = 1'b0;
    for (int c = 0; c <= 8; c++) begin
      @(posedge in_clk); #1;
      applyStimulus(!srch_done, 28'h1234567, 4'd9, (wr_sent < 8), 10'(wr_sent),
                    32'hA000_0000 + 32'(wr_sent), 4'hF, 1'b1);
      @(negedge in_clk);
      check($sformatf("burst_wr_c%0d", c), 64'(out_wr_ready), 64'(c != 4));
      check($sformatf("burst_srch_c%0d", c), 64'(out_srch_ready), 64'(c == 4));
      if (out_wr_ready === 1'b1) wr_sent++;
      if (out_srch_ready === 1'b1) srch_done = 1'b1;
    end
    checkOutput("burst");

    // Credit limit with the response channel stalled.
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge in_clk); #1;
      applyStimulus((accepted < 6), 28'h0100000 + 28'(accepted), 4'(accepted),
                    1'b0, '0, '0, '0, 1'b0);
      @(negedge in_clk);
      if (in_srch_valid && out_srch_ready === 1'b1) accepted++;
    end
    check("credit_accepted4", 64'(accepted), 64'd4);
    check("credit_blocked", 64'(out_srch_ready), 64'd0);
    @(posedge in_clk); #1;
    in_rsp_ready = 1'b1;
    @(posedge in_clk); #1;
    in_rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge in_clk);
      if (in_srch_valid && out_srch_ready === 1'b1) accepted++;
      @(posedge in_clk); #1;
      in_srch_valid = (accepted < 6);
      in_srch_key   = 28'h0100000 + 28'(accepted);
      in_srch_tag   = 4'(accepted);
    end
    check("credit_one_more", 64'(accepted), 64'd5);
    check("credit_blocked2", 64'(out_srch_ready), 64'd0);
    in_rsp_ready = 1'b1;
    for (int c = 0; c < 30 && accepted < 6; c++) begin
      @(negedge in_clk);
      if (in_srch_valid && out_srch_ready === 1'b1) accepted++;
      @(posedge in_clk); #1;
      in_srch_valid = (accepted < 6);
    end
    check("credit_all6", 64'(accepted), 64'd6);
    checkOutput("credit");

    // Reset one cycle after a search grant: result is dropped.
    @(posedge in_clk); #1;
    applyStimulus(1'b1, 28'h0000055, 4'd5, 1'b0, '0, '0, '0, 1'b1);
    @(negedge in_clk);
    check("rst2_grant", 64'(out_srch_ready), 64'd1);
    @(posedge in_clk); #1;
    in_srch_valid = 1'b0;
    #1;
    check("rst2_port_busy", 64'(out_mem_csb), 64'd0);
    in_rstn = 1'b0;
    #1;
    check("rst2_port_idle", 64'(out_mem_csb), 64'd1);
    sb.delete();
    @(posedge in_clk); #1;
    in_rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge in_clk);
      check($sformatf("rst2_no_rsp%0d", c), 64'(out_rsp_valid), 64'd0);
    end
    check("rst2_idle", 64'(out_idle), 64'd1);

    // Random searches and writes with stalls and releases of the response side.
    accepted = 0;
    for (int cyc = 0; cyc < 4000 && accepted < 100; cyc++) begin
      @(posedge in_clk); #1;
      applyStimulus(($urandom_range(0, 3) != 0), 28'($urandom), 4'(accepted),
                    ($urandom_range(0, 7) == 0), 10'($urandom), $urandom, 4'($urandom),
                    ((cyc % 40) < 12) ? 1'b0 : ($urandom_range(0, 3) != 0));
      @(negedge in_clk);
      if (in_srch_valid && out_srch_ready === 1'b1) accepted++;
    end
    check("rand_accepted", 64'(accepted), 64'd100);
    checkOutput("rand");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
